ana_frame_scheduler: RTL and testbench

//  Shares one peak-bin analysis unit (16-bin magnitude-max engine, fixed 17-cycle frame time) among
//  NCH FFT frame producers. Round-robin grants one frame per analysis slot, drives the analyser's

---
 rtl/ana_pkg.sv | 20 ++
 rtl/ana_res_fifo.sv | 51 +++++
 rtl/ana_frame_scheduler.sv | 130 +++++++++++++
 tb/tb_ana_frame_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ana_pkg.sv
// Shared definitions for the frame scheduler: analyser timing, result format
// and the scheduler FSM encoding.
package ana_pkg;

  localparam int ANA_FRAME_CYC = 17;
  localparam int BIN_CNT       = 16;
  localparam int FREQ_W        = $clog2(BIN_CNT);
  localparam int CH_W_MAX      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ana_state_e;

  typedef struct packed {
    logic [CH_W_MAX-1:0] ch;
    logic [FREQ_W-1:0]   freq;
  } ana_res_t;

endpackage

// File: rtl/ana_res_fifo.sv
// Small synchronous result FIFO; head entry and occupancy come straight from
// registers so the sink sees a glitch-free interface.
module ana_res_fifo
  import ana_pkg::*;
#(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (cnt_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);

  // NOTE: storage is deliberately not reset; only pointers and count define
  // which entries are meaningful, so the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_ok);
      rd_q  <= rd_q + AW'(pop_ok);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ana_frame_scheduler.sv
// Round-robin scheduler sharing one peak-bin analyser among NCH FFT channels;
// completed {channel, peak bin} results are queued for the sink.
module ana_frame_scheduler
  import ana_pkg::*;
#(
  parameter  int NCH        = 4,
  parameter  int ANA_LAT    = ANA_FRAME_CYC,
  parameter  int FIFO_DEPTH = 4,
  localparam int CHW        = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NCH-1:0]    req,
  output logic [NCH-1:0]    gnt,
  output logic              ana_valid,
  input  logic [FREQ_W-1:0] ana_freq,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CHW-1:0]    res_ch,
  output logic [FREQ_W-1:0] res_freq,
  output logic              busy,
  output logic [15:0]       frames_done
);

  localparam int SLOT_W = $clog2(ANA_LAT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  ana_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CHW-1:0]    tag_q, tag_d;
  logic [CHW-1:0]    ptr_q, ptr_d;
  logic [15:0]       frames_done_q;

  logic [2*NCH-1:0]  req_dbl;
  logic [NCH-1:0]    req_rot;
  logic [CHW:0]      rot_sh;
  int                enc, win_sum;
  logic [CHW-1:0]    win;

  logic              slot_free, credit_ok, grant, complete;
  logic              fifo_push;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CHW+FREQ_W-1:0] head_data;

  // Rotate so the channel after the pointer sits at bit 0, pick the lowest
  // set bit, then rotate the index back to a channel number.
  always_comb begin
    rot_sh  = {1'b0, ptr_q} + 1'b1;
    req_dbl = {req, req};
    req_rot = req_dbl[rot_sh +: NCH];
    enc     = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_rot[i]) enc = i;
    end
    win_sum = int'(rot_sh) + enc;
    if (win_sum >= NCH) win_sum = win_sum - NCH;
    win = CHW'(win_sum);
  end

  assign busy      = (state_q == BUSY);
  assign complete  = busy && (slot_q == '0);
  assign slot_free = (state_q == IDLE) || (slot_q == '0);
  // A frame in flight already owns a FIFO slot; a same-cycle pop is not credited.
  assign credit_ok = (int'(fifo_cnt) + int'(busy)) < FIFO_DEPTH;
  assign grant     = !rst && en && (|req) && slot_free && credit_ok;

  always_comb begin
    gnt = '0;
    if (grant) gnt[win] = 1'b1;
  end

  assign ana_valid = |gnt;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    if (busy && (slot_q != '0)) slot_d = slot_q - 1'b1;
    if (complete) state_d = IDLE;
    if (grant) begin
      state_d = BUSY;
      slot_d  = SLOT_W'(ANA_LAT - 1);
      tag_d   = win;
      ptr_d   = win;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      tag_q         <= '0;
      ptr_q         <= CHW'(NCH - 1);
      frames_done_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
      if (complete) frames_done_q <= frames_done_q + 16'd1;
    end
  end

  assign fifo_push   = complete;
  assign frames_done = frames_done_q;

  ana_res_fifo #(
    .WIDTH (CHW + FREQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  ({tag_q, ana_freq}),
    .pop_i   (res_valid && res_ready),
    .valid_o (res_valid),
    .data_o  (head_data),
    .count_o (fifo_cnt)
  );

  assign res_ch   = head_data[FREQ_W +: CHW];
  assign res_freq = head_data[FREQ_W-1:0];

endmodule

// File: tb/tb_ana_frame_scheduler.sv
// Scoreboard bench for ana_frame_scheduler: directed scenarios plus random
// producers, checked against a cycle-level behavioural model.
module tb_ana_frame_scheduler;
  import ana_pkg::*;

  localparam int NCH   = 4;
  localparam int LAT   = 17;
  localparam int DEPTH = 4;
  localparam int CHW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              res_ready = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic [NCH-1:0]    gnt;
  logic              ana_valid;
  logic [3:0]        ana_freq = '0;
  logic              res_valid;
  logic [CHW-1:0]    res_ch;
  logic [3:0]        res_freq;
  logic              busy;
  logic [15:0]       frames_done;

  always #5 clk = ~clk;

  ana_frame_scheduler #(.NCH(NCH), .ANA_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .gnt(gnt), .ana_valid(ana_valid),
    .ana_freq(ana_freq), .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_freq(res_freq), .busy(busy), .frames_done(frames_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of results the sink should see, in order.
  ana_res_t sb[$];

  // Behavioural model: one analyser slot, a FIFO occupancy count, last winner.
  int cyc = 0;
  int m_inflight, m_done_at, m_tag, m_occ, m_rr, m_frames;
  int freq_hold = -1;
  logic [NCH-1:0] obs_gnt;
  int obs_cyc[$];
  int obs_ch[$];

  task automatic model_reset();
    m_inflight = 0;
    m_occ      = 0;
    m_rr       = NCH - 1;
    m_frames   = 0;
    sb.delete();
  endtask

  task automatic step(input logic [NCH-1:0] r, input logic e, input logic rdy, input logic rs);
    int win;
    bit complete, cond, pop;
    logic [NCH-1:0] eg;
    @(posedge clk);
    #1;
    req       = r;
    en        = e;
    res_ready = rdy;
    rst       = rs;
    ana_freq  = (freq_hold >= 0) ? 4'(freq_hold) : 4'($urandom_range(0, 15));
    #1;
    complete = (m_inflight != 0) && (cyc == m_done_at);
    win = -1;
    for (int k = 1; k <= NCH; k++) begin
      int ch = (m_rr + k) % NCH;
      if (win < 0 && r[ch]) win = ch;
    end
    cond = !rs && e && (win >= 0) && (m_inflight == 0 || complete) && (m_occ + m_inflight < DEPTH);
    eg = cond ? (NCH'(1) << win) : '0;
    check("gnt", 32'(gnt), 32'(eg));
    check("ana_valid", 32'(ana_valid), 32'(|eg));
    check("busy", 32'(busy), 32'(m_inflight));
    check("res_valid", 32'(res_valid), 32'(m_occ > 0));
    check("frames_done", 32'(frames_done), 32'(m_frames));
    obs_gnt = gnt;
    for (int c = 0; c < NCH; c++) begin
      if (gnt[c]) begin
        obs_cyc.push_back(cyc);
        obs_ch.push_back(c);
      end
    end
    if (rs) begin
      model_reset();
    end else begin
      pop = (m_occ > 0) && rdy;
      if (complete) begin
        sb.push_back('{ch: CH_W_MAX'(m_tag), freq: ana_freq});
        m_frames   = (m_frames + 1) % 65536;
        m_inflight = 0;
        m_occ++;
      end
      if (pop) m_occ--;
      if (cond) begin
        m_inflight = 1;
        m_done_at  = cyc + LAT;
        m_tag      = win;
        m_rr       = win;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b1, 1'b1);
    obs_cyc.delete();
    obs_ch.delete();
  endtask

  // Monitor: compares every accepted result against the scoreboard head.
  initial begin
    ana_res_t exp_r;
    forever begin
      @(posedge clk);
      #3;
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got ch=%0d freq=%0d with nothing expected", res_ch, res_freq);
        end else begin
          exp_r = sb.pop_front();
          check("res_ch", 32'(res_ch), 32'(exp_r.ch));
          check("res_freq", 32'(res_freq), 32'(exp_r.freq));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && dut.fifo_push) check("push_when_full", 32'(dut.fifo_cnt == DEPTH), 32'd0);
  end

  initial begin
    logic [NCH-1:0] pend;
    int n;
    model_reset();
    step('0, 1'b0, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1, 1'b1);
    step('0, 1'b1, 1'b1, 1'b0);

    // 1: single frame, peak bin 9 held
    do_reset();
    freq_hold = 9;
    step(4'b0100, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) step('0, 1'b1, 1'b1, 1'b0);
    check("single_grants", 32'(obs_ch.size()), 32'd1);
    check("single_frames", 32'(frames_done), 32'd1);
    freq_hold = -1;

    // 2: fairness with all channels requesting
    do_reset();
    for (int i = 0; i < 5 * LAT + 1; i++) step(4'b1111, 1'b1, 1'b1, 1'b0);
    check("fair_count", 32'(obs_ch.size()), 32'd6);
    for (int i = 0; i < 5 && i < obs_ch.size(); i++) begin
      check("fair_ch", 32'(obs_ch[i]), 32'(i % NCH));
      check("fair_gap", 32'(obs_cyc[i] - obs_cyc[0]), 32'(LAT * i));
    end
    for (int i = 0; i < 25; i++) step('0, 1'b1, 1'b1, 1'b0);

    // 3: backpressure fills the FIFO, one pop re-opens the slot
    do_reset();
    for (int i = 0; i < 100; i++) step(4'b0001, 1'b1, 1'b0, 1'b0);
    check("bp_grants", 32'(obs_ch.size()), 32'd4);
    step(4'b0001, 1'b1, 1'b1, 1'b0);
    check("bp_no_grant_on_pop", 32'(obs_gnt), 32'd0);
    step(4'b0001, 1'b1, 1'b1, 1'b0);
    check("bp_resume", 32'(obs_gnt), 32'b0001);
    for (int i = 0; i < 60; i++) step('0, 1'b1, 1'b1, 1'b0);

    // 4: en dropped mid-frame
    do_reset();
    step(4'b0011, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) step(4'b0011, 1'b1, 1'b1, 1'b0);
    for (int i = 5; i < 40; i++) step(4'b0011, 1'b0, 1'b1, 1'b0);
    check("endrop_grants", 32'(obs_ch.size()), 32'd1);
    check("endrop_frames", 32'(frames_done), 32'd1);

    // 5: reset in the middle of a frame
    do_reset();
    step(4'b0001, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) step('0, 1'b1, 1'b1, 1'b0);
    step('0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) step('0, 1'b1, 1'b1, 1'b0);
    check("rst_frames", 32'(frames_done), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);

    // 6: completed-frame counter wraps
    do_reset();
    force dut.frames_done_q = 16'hFFFF;
    m_frames = 65535;
    step('0, 1'b0, 1'b1, 1'b0);
    release dut.frames_done_q;
    step('0, 1'b0, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step('0, 1'b1, 1'b1, 1'b0);
    check("wrap_frames", 32'(frames_done), 32'd0);

    // 7: random producers, enable, sink stalls and rare resets
    do_reset();
    pend = '0;
    n = 3000;
    for (int i = 0; i < n; i++) begin
      step(pend, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 499) == 0));
      pend = pend & ~obs_gnt;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 7) == 0) pend[c] = 1'b1;
      end
    end
    for (int i = 0; i < 120; i++) step('0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #5;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
